fixed_float_conversion: RTL
===========================

Name: fixed_float_conversion

Overview:
Converts a 22-bit sign-magnitude fixed-point value (1 sign, 1 integer, 20 fractional bits) to IEEE-754 single precision. It is the inverse of the float-to-fixed converter in the conversions path, so fixed-point datapath results can re-enter the floating-point units. Normalisation is iterative: one left shift per cycle, with an enable/busy/done handshake.

Parameters:
FRAC_BITS, 20, fractional bits of the fixed format; magnitude width is FRAC_BITS+1 and input width is FRAC_BITS+2.
FLOAT_BIAS, 127, IEEE-754 single-precision exponent bias.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
enable  input  1  start request; sampled only in IDLE
data  input  22  fixed-point operand; bit 21 = sign, bit 20 = weight 2^0, bit 0 = weight 2^-20
busy  output  1  high while a conversion is in progress (NORM state)
done  output  1  one-cycle pulse; result valid and updated in this cycle
result  output  32  IEEE-754 single; holds the last value until the next completion

Behaviour:
- Reset (async, rst=1): state=IDLE, result=32'h0, done=0, busy=0; internal sign, magnitude and exponent registers cleared. Reset during NORM aborts the conversion; no done pulse.
- States: IDLE, NORM.
- IDLE: on a clk edge with enable=1:
  - capture sign=data[21], mag=data[20:0] and exp=FLOAT_BIAS;
  - go to NORM and set busy=1.
  - enable=0 keeps the block in IDLE.
- NORM: each edge evaluates, in priority order:
  - mag==0: result=32'h00000000. A negative zero input also yields +0. Set done=1, busy=0, go to IDLE.
  - mag[20]==1: result={sign, exp[7:0], mag[19:0], 3'b000}; the hidden bit is dropped. Set done=1, busy=0, go to IDLE.
  - otherwise: mag<=mag<<1, exp<=exp-1, stay in NORM.
- Arithmetic rules:
  - The exponent range is 107..127, so it never underflows and no denormals occur.
  - The conversion is exact; no rounding, because 20 fraction bits fit in 23.
- Latency:
  - Let k = number of leading zeros of mag above its leading one (0..20); zero input counts as k=0.
  - done is high in the cycle after edge E0+k+1, where E0 is the edge that accepted enable.
  - Minimum latency is 1 edge after acceptance; maximum is 21 edges (data=22'h000001).
- done is high for exactly one cycle and is otherwise 0.
- enable while busy=1 is ignored; there is no queueing.
- enable sampled on the edge that ends the done cycle is accepted (state is already IDLE). This allows back-to-back conversions with one idle-free turnaround; done then drops.
- data only needs to be stable at the accepting edge.
- result changes only on a completion edge or on reset.

Decomposition:
- Shared conversions package holds:
  - FLOAT_BIAS, FLOAT_EXP_W=8, FLOAT_MANT_W=23;
  - FIXED_FRAC_BITS=20, FIXED_W=22;
  - the state enum {IDLE, NORM}.
- The same constants serve the float-to-fixed converter.
- No sub-module: the normaliser is a shift register plus exponent decrementer inside this module.

Test Plan:
- Reset mid-conversion: enable with data=22'h000001, assert rst at E5 -> result=32'h0, done never pulses, busy=0; a new enable is accepted after reset deasserts.
- data=22'h100000 (1.0) -> result=32'h3F800000, done after E1. data=22'h300000 (-1.0) -> 32'hBF800000, done after E1.
- data=22'h080000 (0.5) -> 32'h3F000000 after E2. data=22'h1C0000 (1.75) -> 32'h3FE00000 after E1.
- Extremes:
  - data=22'h000001 (2^-20) -> 32'h35800000; done after E21; busy high E0..E21.
  - data=22'h1FFFFF -> 32'h3FFFFFF8 after E1.
- Zero: data=22'h000000 and data=22'h200000 -> 32'h00000000, done after E1.
- Handshake:
  - enable held high continuously with changing data -> operands captured only in IDLE; a second conversion starts on the edge after each done; no double done.
  - enable pulses while busy are ignored.

Source files
------------

// File: rtl/fixed_float_conversion_pkg.sv
// Shared constants and types for the fixed <-> float conversion path.
// Used by both the fixed-to-float and the float-to-fixed converters.
package fixed_float_conversion_pkg;

  localparam int FLOAT_BIAS      = 127;
  localparam int FLOAT_EXP_W     = 8;
  localparam int FLOAT_MANT_W    = 23;
  localparam int FIXED_FRAC_BITS = 20;
  localparam int FIXED_W         = 22;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } conv_state_e;

endpackage : fixed_float_conversion_pkg

// File: rtl/fixed_float_conversion.sv
// Sign-magnitude fixed point (1 sign, 1 integer, FRAC_BITS fraction) to
// IEEE-754 single precision, using an iterative normaliser that shifts the
// magnitude left by one position per cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   enable  start request, sampled only while idle
//   data    fixed-point operand: [FRAC_BITS+1] sign, [FRAC_BITS] weight 2^0
//   busy    high while normalising
//   done    one-cycle pulse when result is updated
//   result  IEEE-754 single, held until the next completion
//
// state | meaning
// IDLE  | waiting for enable; captures operand when it arrives
// NORM  | shifting magnitude left until its top bit is set (or it is zero)
module fixed_float_conversion
  import fixed_float_conversion_pkg::*;
#(
  parameter int FRAC_BITS  = fixed_float_conversion_pkg::FIXED_FRAC_BITS,
  parameter int FLOAT_BIAS = fixed_float_conversion_pkg::FLOAT_BIAS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [FRAC_BITS+1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          result
);

  localparam int MAG_W = FRAC_BITS + 1;

  conv_state_e            state_q, state_d;
  logic                   sign_q, sign_d;
  logic [MAG_W-1:0]       mag_q, mag_d;
  logic [FLOAT_EXP_W-1:0] exp_q, exp_d;
  logic [31:0]            result_q, result_d;
  logic                   done_q, done_d;

  // Normalisation finishes either on a zero magnitude or once the leading
  // one sits in the integer position.
  logic mag_zero;
  logic mag_norm;
  assign mag_zero = (mag_q == '0);
  assign mag_norm = mag_q[MAG_W-1];

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = NORM;
      NORM:    if (mag_zero || mag_norm) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs
  always_comb begin
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          sign_d = data[FRAC_BITS+1];
          mag_d  = data[FRAC_BITS:0];
          exp_d  = FLOAT_EXP_W'(FLOAT_BIAS);
        end
      end
      NORM: begin
        busy = 1'b1;
        if (mag_zero) begin
          // Negative zero is folded to +0.
          result_d = '0;
          done_d   = 1'b1;
        end else if (mag_norm) begin
          // Hidden bit dropped; fraction padded on the right, conversion exact.
          result_d = {sign_q, exp_q, mag_q[FRAC_BITS-1:0],
                      {(FLOAT_MANT_W-FRAC_BITS){1'b0}}};
          done_d   = 1'b1;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - FLOAT_EXP_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule : fixed_float_conversion
